// File: rtl/relu_f2_pkg.sv
// Shared types and constants for the ReLU int-to-float scheduler.
package relu_f2_pkg;
  localparam int         INT_W    = 32;
  localparam int         FLT_W    = 31;
  localparam int         MANT_W   = 23;
  localparam logic [7:0] EXP_BIAS = 8'd127;

  // Mantissa keeps the leading one explicitly in mant[22].
  typedef struct packed {
    logic [7:0]        exp;
    logic [MANT_W-1:0] mant;
  } flt_t;
endpackage

// File: rtl/relu_f2_sched_if.sv
// Lane-request and result bus between the accumulator lanes, the scheduler and write-back.
interface relu_f2_sched_if #(
  parameter int NUM_LANES = 4
);
  localparam int LANE_W = $clog2(NUM_LANES);

  logic [NUM_LANES-1:0]    i_valid;
  logic [NUM_LANES*32-1:0] i_data;
  logic [NUM_LANES-1:0]    o_ready;
  logic                    o_valid;
  logic [30:0]             o_float;
  logic [LANE_W-1:0]       o_lane;
  logic                    i_ready;

  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_float, o_lane
  );

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_float, o_lane
  );
endinterface

// File: rtl/relu_f2_sched_arb.sv
// Round-robin arbiter: first requester at or after i_ptr, searching upward modulo N.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int LW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [LW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [LW-1:0] o_idx,
  output logic          o_any
);
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!o_any && i_req[(int'(i_ptr) + k) % N]) begin
        o_any = 1'b1;
        o_idx = LW'((int'(i_ptr) + k) % N);
        o_grant[(int'(i_ptr) + k) % N] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/relu_f2_sched_conv.sv
// Combinational ReLU + int-to-float: negatives and zero map to 0, else explicit-one mantissa.
module float_converter
  import relu_f2_pkg::*;
(
  input  logic [INT_W-1:0] i_data,
  output flt_t             o_flt
);
  logic [4:0]        w_p;
  logic [MANT_W-1:0] w_mant;

  always_comb begin
    w_p = '0;
    for (int i = 0; i < INT_W - 1; i++) begin
      if (i_data[i]) w_p = 5'(i);
    end
  end

  // Align the leading one to mant[22]: truncate below it, or zero-pad small values.
  always_comb begin
    if (w_p >= 5'd22) w_mant = MANT_W'(i_data >> (w_p - 5'd22));
    else              w_mant = MANT_W'(i_data << (5'd22 - w_p));
  end

  always_comb begin
    o_flt = '0;
    if (!i_data[INT_W-1] && (|i_data[INT_W-2:0])) begin
      o_flt.exp  = EXP_BIAS + {3'b000, w_p};
      o_flt.mant = w_mant;
    end
  end
endmodule

// File: rtl/relu_f2_sched.sv
// Shares one ReLU float converter between NUM_LANES lanes with round-robin grant.
// Optional macro RELU_STATS_EN adds saturating conversion / clip counters.
module relu_f2_sched
  import relu_f2_pkg::*;
#(
  parameter  int NUM_LANES = 4,
  localparam int LANE_W    = $clog2(NUM_LANES)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  relu_f2_sched_if.slave bus
`ifdef RELU_STATS_EN
  ,
  output logic [31:0]   o_clip_cnt,
  output logic [31:0]   o_conv_cnt
`endif
);
  logic [INT_W-1:0]     w_lane_data [NUM_LANES];
  logic [NUM_LANES-1:0] w_grant;
  logic [LANE_W-1:0]    w_idx;
  logic                 w_any;
  logic                 w_take;
  logic [INT_W-1:0]     w_sel;
  flt_t                 w_flt;
  logic [LANE_W-1:0]    w_ptr_next;

  logic                 r_valid;
  flt_t                 r_float;
  logic [LANE_W-1:0]    r_lane;
  logic [LANE_W-1:0]    r_ptr;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    assign w_lane_data[gi] = bus.i_data[INT_W*gi +: INT_W];
  end

  rr_arbiter #(.N(NUM_LANES)) u_arb (
    .i_req   (bus.i_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_sel = w_lane_data[w_idx];

  float_converter u_conv (
    .i_data (w_sel),
    .o_flt  (w_flt)
  );

  // Reset also masks o_ready so no lane believes it was accepted while held in reset.
  assign w_take      = !i_rst && w_any && (!r_valid || bus.i_ready);
  assign bus.o_ready = w_take ? w_grant : '0;
  assign w_ptr_next  = (w_idx == LANE_W'(NUM_LANES - 1)) ? '0 : w_idx + LANE_W'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_float <= '0;
      r_lane  <= '0;
      r_ptr   <= '0;
    end else if (w_take) begin
      r_valid <= 1'b1;
      r_float <= w_flt;
      r_lane  <= w_idx;
      r_ptr   <= w_ptr_next;
    end else if (r_valid && bus.i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.o_valid = r_valid;
  assign bus.o_float = r_float;
  assign bus.o_lane  = r_lane;

`ifdef RELU_STATS_EN
  logic [31:0] r_clip_cnt;
  logic [31:0] r_conv_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_clip_cnt <= '0;
      r_conv_cnt <= '0;
    end else if (w_take) begin
      if (r_conv_cnt != '1) r_conv_cnt <= r_conv_cnt + 32'd1;
      if (w_sel[INT_W-1] && (r_clip_cnt != '1)) r_clip_cnt <= r_clip_cnt + 32'd1;
    end
  end

  assign o_clip_cnt = r_clip_cnt;
  assign o_conv_cnt = r_conv_cnt;
`endif
endmodule

// File: tb/tb_relu_f2_sched.sv
// Scoreboard bench for relu_f2_sched: reference model of arbitration and conversion.
module tb_relu_f2_sched;
  localparam int NL = 4;
  localparam int LW = $clog2(NL);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  relu_f2_sched_if #(.NUM_LANES(NL)) bus ();

`ifdef RELU_STATS_EN
  logic [31:0] clip_cnt, conv_cnt;
`endif

  relu_f2_sched #(.NUM_LANES(NL)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
`ifdef RELU_STATS_EN
    ,
    .o_clip_cnt (clip_cnt),
    .o_conv_cnt (conv_cnt)
`endif
  );

  typedef struct {
    int          lane;
    logic [30:0] f;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   m_ptr  = 0;
  bit   m_ov   = 1'b0;

  // Reference conversion built bit by bit from the leading one downward.
  function automatic logic [30:0] ref_conv(logic [31:0] d);
    logic [7:0]  e;
    logic [22:0] m;
    int          p;
    if (d[31] || d == 32'd0) return '0;
    p = 30;
    while (!d[p]) p--;
    e = 8'(127 + p);
    m = '0;
    for (int k = 0; k < 23; k++) begin
      if (p - k >= 0) m[22-k] = d[p-k];
    end
    return {e, m};
  endfunction

  task automatic set_lane(input int l, input logic [31:0] v);
    bus.i_data[32*l +: 32] = v;
  endtask

  // One clock: entered at a falling edge with inputs already driven, returns at the next falling edge.
  task automatic tick(output int g);
    logic [NL-1:0] exp_rdy;
    bit            take;
    exp_t          e;
    #1;
    g = -1;
    take = (bus.i_valid != '0) && (!m_ov || bus.i_ready);
    if (take) begin
      for (int k = 0; k < NL; k++) begin
        if (g < 0 && bus.i_valid[(m_ptr + k) % NL]) g = (m_ptr + k) % NL;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;

    checks++;
    if (bus.o_valid !== m_ov) begin
      errors++;
      $display("FAIL o_valid got %0b want %0b at %0t", bus.o_valid, m_ov, $time);
    end
    checks++;
    if (bus.o_ready !== exp_rdy) begin
      errors++;
      $display("FAIL o_ready got %b want %b at %0t", bus.o_ready, exp_rdy, $time);
    end

    if (m_ov && bus.i_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty got lane %0d float %h want none", bus.o_lane, bus.o_float);
      end else begin
        e = sb.pop_front();
        if (bus.o_float !== e.f || bus.o_lane !== LW'(e.lane)) begin
          errors++;
          $display("FAIL result got lane %0d float %h want lane %0d float %h",
                   bus.o_lane, bus.o_float, e.lane, e.f);
        end else begin
          $display("result lane %0d float %h", bus.o_lane, bus.o_float);
        end
      end
    end

    if (g >= 0) begin
      e.lane = g;
      e.f    = ref_conv(bus.i_data[32*g +: 32]);
      sb.push_back(e);
      m_ptr = (g + 1) % NL;
      m_ov  = 1'b1;
    end else if (m_ov && bus.i_ready) begin
      m_ov = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    bus.i_valid = '1;
    bus.i_data  = '0;
    bus.i_ready = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_float !== 31'h0 || bus.o_lane !== '0 || bus.o_ready !== '0) begin
      errors++;
      $display("FAIL reset_state got v=%0b f=%h l=%0d r=%b want 0", bus.o_valid, bus.o_float,
               bus.o_lane, bus.o_ready);
    end
    @(negedge clk);
    rst         = 1'b0;
    bus.i_valid = '0;
    m_ptr       = 0;
    m_ov        = 1'b0;
  endtask

  task automatic test_single();
    int g;
    set_lane(0, 32'd1);
    bus.i_valid = 4'b0001;
    bus.i_ready = 1'b1;
    tick(g);
    bus.i_valid = '0;
    #1;
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_float !== 31'h3FC0_0000 || bus.o_lane !== 2'd0) begin
      errors++;
      $display("FAIL single got v=%0b f=%h l=%0d want v=1 f=3fc00000 l=0", bus.o_valid,
               bus.o_float, bus.o_lane);
    end
    tick(g);
  endtask

  task automatic test_two_lanes();
    int g;
`ifdef RELU_STATS_EN
    logic [31:0] clip0, conv0;
    clip0 = clip_cnt;
    conv0 = conv_cnt;
`endif
    set_lane(1, 32'h4000_0000);
    set_lane(2, 32'hFFFF_FFFB);
    bus.i_valid = 4'b0110;
    tick(g);
    bus.i_valid = 4'b0100;
    #1;
    checks++;
    if (bus.o_float !== 31'h4EC0_0000 || bus.o_lane !== 2'd1) begin
      errors++;
      $display("FAIL two_lanes_a got f=%h l=%0d want f=4ec00000 l=1", bus.o_float, bus.o_lane);
    end
    tick(g);
    bus.i_valid = '0;
    #1;
    checks++;
    if (bus.o_float !== 31'h0 || bus.o_lane !== 2'd2) begin
      errors++;
      $display("FAIL two_lanes_b got f=%h l=%0d want f=0 l=2", bus.o_float, bus.o_lane);
    end
`ifdef RELU_STATS_EN
    checks++;
    if (clip_cnt - clip0 !== 32'd1 || conv_cnt - conv0 !== 32'd2) begin
      errors++;
      $display("FAIL stats got clip+%0d conv+%0d want clip+1 conv+2", clip_cnt - clip0,
               conv_cnt - conv0);
    end
`endif
    tick(g);
  endtask

  task automatic test_back_to_back();
    int g;
    for (int l = 0; l < NL; l++) set_lane(l, $urandom());
    bus.i_valid = '1;
    bus.i_ready = 1'b1;
    repeat (10) begin
      tick(g);
      if (g >= 0) set_lane(g, $urandom());
    end
    bus.i_valid = '0;
    tick(g);
  endtask

  task automatic test_backpressure();
    int          g;
    logic [30:0] hf;
    logic [LW-1:0] hl;
    set_lane(0, 32'h0001_2345);
    bus.i_valid = 4'b0001;
    bus.i_ready = 1'b1;
    tick(g);
    set_lane(0, 32'h0000_0AAA);
    set_lane(1, 32'h0000_00FF);
    bus.i_valid = 4'b0011;
    bus.i_ready = 1'b0;
    #1;
    hf = bus.o_float;
    hl = bus.o_lane;
    repeat (3) begin
      tick(g);
      checks++;
      if (bus.o_float !== hf || bus.o_lane !== hl) begin
        errors++;
        $display("FAIL stall_hold got f=%h l=%0d want f=%h l=%0d", bus.o_float, bus.o_lane, hf, hl);
      end
    end
    bus.i_ready = 1'b1;
    tick(g);
    bus.i_valid = 4'b0001;
    tick(g);
    bus.i_valid = '0;
    tick(g);
  endtask

  task automatic test_boundaries();
    int          g;
    logic [31:0] vin  [7] = '{32'h0, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0040_0000,
                              32'h0080_0000, 32'h0000_0003, 32'h0080_0001};
    logic [30:0] vexp [7] = '{31'h0, 31'h4EFF_FFFF, 31'h0, 31'h4AC0_0000,
                              31'h4B40_0000, 31'h4060_0000, 31'h4B40_0000};
    bus.i_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      set_lane(i % NL, vin[i]);
      bus.i_valid = '0;
      bus.i_valid[i % NL] = 1'b1;
      tick(g);
      bus.i_valid = '0;
      #1;
      checks++;
      if (bus.o_float !== vexp[i]) begin
        errors++;
        $display("FAIL boundary_%0d in %h got %h want %h", i, vin[i], bus.o_float, vexp[i]);
      end
      tick(g);
    end
  endtask

  task automatic test_async_reset();
    int g;
    set_lane(1, 32'h0000_1000);
    set_lane(3, 32'h0000_0010);
    bus.i_valid = 4'b0010;
    bus.i_ready = 1'b1;
    tick(g);
    bus.i_valid = 4'b1010;
    bus.i_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_float !== 31'h0 || bus.o_ready !== '0) begin
      errors++;
      $display("FAIL async_reset got v=%0b f=%h r=%b want 0", bus.o_valid, bus.o_float, bus.o_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    m_ptr = 0;
    m_ov  = 1'b0;
    bus.i_ready = 1'b1;
    #1;
    checks++;
    if (bus.o_ready !== 4'b0010) begin
      errors++;
      $display("FAIL post_reset_grant got %b want 0010", bus.o_ready);
    end
    tick(g);
    bus.i_valid = 4'b1000;
    tick(g);
    bus.i_valid = '0;
    tick(g);
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_lanes();
    test_back_to_back();
    test_backpressure();
    test_boundaries();
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/relu_f2_sched.md
Name: relu_f2_sched

Overview:
- Round-robin scheduler that shares one integer-to-float ReLU conversion stage between NUM_LANES accumulator lanes.
- Each lane offers a signed 32-bit accumulator result over a valid/ready handshake.
- The scheduler grants one lane per cycle, converts its result, and emits a registered 31-bit float tagged with the source lane.
- Sits between the PE accumulator array and the activation write-back buffer.

Parameters:
- NUM_LANES, 4, number of requesting lanes (2..16)
- LANE_W, $clog2(NUM_LANES), width of lane-id tag (derived; do not override)

Ports:
- i_clk  input  1  clock, rising edge
- i_rst  input  1  asynchronous active-high reset
- i_valid  input  NUM_LANES  per-lane request valid
- i_data  input  NUM_LANES*32  per-lane signed int; lane k = bits [32k+31:32k]
- o_ready  output  NUM_LANES  per-lane accept, one-hot or zero
- o_valid  output  1  converted result valid
- o_float  output  31  result: {exp[7:0], mant[22:0]}
- o_lane  output  LANE_W  lane id of o_float
- i_ready  input  1  downstream accept

Behaviour:
- Reset (async, i_rst=1): o_valid=0, o_float=0, o_lane=0, rr pointer=0, o_ready=0. Counters (optional feature) reset to 0.
- Conversion (combinational, in front of the output register):
  - data[31]=1 gives 0 (ReLU).
  - data==0 gives 0.
  - Otherwise, with p = index of the highest set bit (0..30): exp = 127+p, mant = 23 bits taken from data starting at bit p inclusive, downward.
  - If p>22, the bits below p-22 are truncated. If p<22, the low bits are zero-padded.
  - The leading one is stored in mant[22], not hidden.
- Take condition: take = |i_valid && (!o_valid || i_ready).
- Arbitration:
  - Round-robin starting at pointer ptr. The granted lane g is the first lane with i_valid set, searching ptr, ptr+1, ... modulo NUM_LANES.
  - o_ready[g] = take; all other o_ready bits are 0.
  - o_ready is combinational from i_valid, ptr, o_valid and i_ready.
- On take (posedge): o_valid<=1, o_float<=conv(data[g]), o_lane<=g, ptr<=(g+1) mod NUM_LANES.
- No take, with i_ready && o_valid: o_valid<=0. o_float and o_lane hold their last values.
- No take, otherwise: all state holds.
- Latency: 1 cycle from handshake to o_valid. Throughput: 1 result per cycle while i_ready=1.
- Back-pressure: o_valid && !i_ready gives o_ready=0 on all lanes. The output register holds stable, and ptr does not move.
- Simultaneous pop and push (o_valid && i_ready && request present) gives a new result the same cycle, with no bubble.
- ptr wrap: g=NUM_LANES-1 gives ptr=0.
- A lane's i_valid/i_data must stay stable until its o_ready is high. The block does not check this.
- i_rst asserted mid-transfer: any result in flight is dropped and ptr returns to 0. The upstream lanes re-present.

Optional Feature:
- RELU_STATS_EN defined:
  - Adds output o_clip_cnt (32-bit) and output o_conv_cnt (32-bit).
  - On each take: o_conv_cnt increments; o_clip_cnt increments if data[g][31]=1.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0 on i_rst.
- RELU_STATS_EN undefined: neither port nor the counter logic exists.

Decomposition:
- Shared package relu_f2_pkg holds:
  - INT_W=32, FLT_W=31, EXP_BIAS=8'd127
  - a typedef for the {exp, mant} float struct
- The conversion stage is the codebase's existing float_converter, instantiated once.
- The arbiter is a sub-module rr_arbiter (NUM_LANES req, ptr, one-hot grant, grant index).

Test Plan:
- Single lane 0, i_data=32'd1, i_ready=1 -> next cycle o_valid=1, o_float=31'h3FC0_0000, o_lane=0.
- Lane 1 i_data=32'h4000_0000, lane 2 i_data=32'hFFFF_FFFB (-5) -> o_float=31'h4EC0_0000 (lane 1), then 31'h0 (lane 2). With RELU_STATS_EN: o_clip_cnt=1, o_conv_cnt=2.
- All 4 lanes valid continuously, ptr=0, i_ready=1 -> grant order 0,1,2,3,0,...; one result per cycle, no bubbles.
- Output valid with i_ready=0 for 3 cycles -> o_ready=0, o_float/o_lane stable, ptr unchanged; i_ready=1 then resumes with no lost or duplicated results.
- i_data=32'd0 -> o_float=0. i_data=32'h7FFF_FFFF -> o_float={8'd157, 23'h7F_FFFF}, i.e. the low 8 bits are truncated.
- Assert i_rst while o_valid=1 and ptr=2 -> o_valid=0 immediately (async). After release, the first grant goes to the lowest valid lane starting from 0.
